// File: rtl/wdm_pd_scanner.sv
// wdm_pd_scanner
// Sweeps a tunable laser across NUM_WAVES grid channels. On each channel it
// lets the optics settle, averages 2**LOG2_AVG photodetector samples, and
// streams {channel, averaged pd} to the calibration controller over a
// valid/ready port.
module wdm_pd_scanner #(
  parameter int NUM_WAVES  = 8,
  parameter int WVL_W      = 16,
  parameter int PWR_W      = 12,
  parameter int PD_W       = 12,
  parameter int SETTLE_CYC = 4,
  parameter int LOG2_AVG   = 2,
  localparam int CH_W      = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WVL_W-1:0] i_wvl_center,
  input  logic [WVL_W-1:0] i_wvl_spacing,
  input  logic [PWR_W-1:0] i_pwr,
  input  logic [PD_W-1:0]  i_pd_code,
  output logic             o_laser_en,
  output logic [WVL_W-1:0] o_laser_wvl,
  output logic [PWR_W-1:0] o_laser_pwr,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [CH_W-1:0]  o_res_ch,
  output logic [PD_W-1:0]  o_res_pd,
  output logic             o_busy,
  output logic             o_done
);

  localparam int ACC_N   = 1 << LOG2_AVG;
  localparam int ACC_W   = PD_W + LOG2_AVG;
  localparam int CNT_MAX = (SETTLE_CYC > ACC_N) ? SETTLE_CYC : ACC_N;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_N - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_WAVES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TUNE   = 3'd1,
    S_SETTLE = 3'd2,
    S_ACCUM  = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [WVL_W-1:0]   wvl_q, wvl_d;
  logic [WVL_W-1:0]   spc_q, spc_d;
  logic [PWR_W-1:0]   pwr_q, pwr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PD_W-1:0]    res_q, res_d;
  logic [ACC_W-1:0]   acc_sum;

  // Mean of the accumulated window, truncated toward zero.
  function automatic logic [PD_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[LOG2_AVG +: PD_W];
  endfunction

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      wvl_q   <= '0;
      spc_q   <= '0;
      pwr_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wvl_q   <= wvl_d;
      spc_q   <= spc_d;
      pwr_q   <= pwr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath update; abort overrides any non-idle transition.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wvl_d   = wvl_q;
    spc_d   = spc_q;
    pwr_d   = pwr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    acc_sum = acc_q + ACC_W'(i_pd_code);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // Wavelength is tracked incrementally (center, then +spacing per
          // channel), which wraps mod 2**WVL_W exactly like center+ch*spacing.
          wvl_d   = i_wvl_center;
          spc_d   = i_wvl_spacing;
          pwr_d   = i_pwr;
          ch_d    = '0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_TUNE;
        end
      end
      S_TUNE: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYC == 0) ? S_ACCUM : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCUM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACCUM: begin
        if (cnt_q == ACC_LAST) begin
          // Final sample folds straight into the result; accumulator is
          // cleared so the next channel starts from zero.
          res_d   = avg_trunc(acc_sum);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_EMIT;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (i_res_ready) begin
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 1'b1;
            wvl_d   = wvl_q + spc_q;
            state_d = S_TUNE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ch_d    = '0;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  // Outputs decoded from the current state only; idle drives all zeros.
  always_comb begin
    o_laser_en  = 1'b0;
    o_laser_wvl = '0;
    o_laser_pwr = '0;
    o_res_valid = 1'b0;
    o_res_ch    = '0;
    o_res_pd    = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      S_TUNE, S_SETTLE, S_ACCUM: begin
        o_busy      = 1'b1;
        o_laser_en  = 1'b1;
        o_laser_wvl = wvl_q;
        o_laser_pwr = pwr_q;
      end
      S_EMIT: begin
        o_busy      = 1'b1;
        o_laser_en  = 1'b1;
        o_laser_wvl = wvl_q;
        o_laser_pwr = pwr_q;
        o_res_valid = 1'b1;
        o_res_ch    = ch_q;
        o_res_pd    = res_q;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wdm_pd_scanner.sv
// Bench for wdm_pd_scanner: table of sweeps plus a hand-written reset case.
// Expected results are derived from the sweep timing and the pd stimulus and
// queued at start; they are popped as handshakes occur.
module tb_wdm_pd_scanner;

  localparam int NW    = 8;
  localparam int SET   = 4;
  localparam int L2A   = 2;
  localparam int ACC_N = 1 << L2A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort_s = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] center = '0;
  logic [15:0] spacing = '0;
  logic [11:0] pwr = '0;
  logic [11:0] pd = '0;

  logic        o_laser_en;
  logic [15:0] o_laser_wvl;
  logic [11:0] o_laser_pwr;
  logic        o_res_valid;
  logic [2:0]  o_res_ch;
  logic [11:0] o_res_pd;
  logic        o_busy;
  logic        o_done;

  wdm_pd_scanner dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_abort      (abort_s),
    .i_wvl_center (center),
    .i_wvl_spacing(spacing),
    .i_pwr        (pwr),
    .i_pd_code    (pd),
    .o_laser_en   (o_laser_en),
    .o_laser_wvl  (o_laser_wvl),
    .o_laser_pwr  (o_laser_pwr),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (ready),
    .o_res_ch     (o_res_ch),
    .o_res_pd     (o_res_pd),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] center;
    logic [15:0] spacing;
    logic [11:0] pwr;
    int          pd_mode;     // 0 constant, 1 ramp +1 per cycle
    logic [11:0] pd_base;
    int          stall_ch;    // -1 none
    int          stall_len;
    int          abort_ch;    // -1 none; abort in SETTLE of this channel
    int          exp_results;
    int          exp_done;
  } vec_t;

  typedef struct {
    int          ch;
    logic [11:0] pd;
    int          cyc;
  } res_t;

  res_t        sbq[$];
  vec_t        tbl[5];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n = 0;
  int          nhs = 0;
  int          pd_mode = 0;
  logic [11:0] pd_base = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, n);
    end
  endtask

  function automatic logic [11:0] pdv(input int mode, input logic [11:0] base, input int k);
    return (mode != 0) ? (base + 12'(k)) : base;
  endfunction

  // One clock: note a pending handshake, advance past the edge, score it,
  // then drive the pd sample for the new cycle.
  task automatic tick();
    logic        hs;
    logic [2:0]  ch_s;
    logic [11:0] pd_s;
    int          hcyc;
    res_t        e;
    hs   = o_res_valid && ready;
    ch_s = o_res_ch;
    pd_s = o_res_pd;
    hcyc = n;
    @(posedge clk);
    #1;
    n++;
    if (hs) begin
      nhs++;
      if (sbq.size() == 0) begin
        chk("unexpected_result_ch", int'(ch_s), -1);
      end else begin
        e = sbq.pop_front();
        chk("res_ch", int'(ch_s), e.ch);
        chk("res_pd", int'(pd_s), int'(e.pd));
        chk("res_cycle", hcyc, e.cyc);
      end
    end
    pd = pdv(pd_mode, pd_base, n);
  endtask

  task automatic run_sweep(input vec_t v);
    int          T[NW+1];
    int          stl;
    int          emit0;
    int          s;
    int          lim;
    int          c_t;
    int          stall_cnt;
    int          done_seen;
    int          done_cyc;
    int          nhs0;
    bit          fin;
    res_t        e;
    logic [15:0] w;

    pd_mode = v.pd_mode;
    pd_base = v.pd_base;
    // timing model: TUNE(1) + SETTLE + ACCUM + EMIT(>=1)
    T[0] = 0;
    for (int c = 0; c < NW; c++) begin
      stl   = (c == v.stall_ch) ? v.stall_len : 0;
      emit0 = T[c] + 1 + SET + ACC_N;
      T[c+1] = emit0 + stl + 1;
      if (c < v.exp_results) begin
        s = 0;
        for (int k = T[c] + 1 + SET; k < emit0; k++) s += int'(pdv(v.pd_mode, v.pd_base, k));
        e.ch  = c;
        e.pd  = 12'(s >> L2A);
        e.cyc = emit0 + stl;
        sbq.push_back(e);
      end
    end

    center  = v.center;
    spacing = v.spacing;
    pwr     = v.pwr;
    ready   = 1'b1;
    start   = 1'b1;
    n       = -1;
    nhs0    = nhs;
    tick();
    start   = 1'b0;
    center  = 16'($urandom);
    spacing = 16'($urandom);
    pwr     = 12'($urandom);

    lim = (v.abort_ch >= 0) ? v.abort_ch : NW - 1;
    c_t = 0;
    stall_cnt = 0;
    done_seen = 0;
    done_cyc  = -1;
    fin = 1'b0;
    for (int i = 0; i < 600 && !fin; i++) begin
      if (c_t <= lim && n == T[c_t]) begin
        w = v.center + 16'(c_t * int'(v.spacing));
        chk("tune_laser_en", int'(o_laser_en), 1);
        chk("tune_wvl", int'(o_laser_wvl), int'(w));
        chk("tune_pwr", int'(o_laser_pwr), int'(v.pwr));
        c_t++;
      end
      // a start pulse mid-sweep with fresh config must change nothing
      if (n == 3) begin
        start   = 1'b1;
        center  = 16'($urandom);
        spacing = 16'($urandom);
        pwr     = 12'($urandom);
      end else begin
        start = 1'b0;
      end
      if (o_done) begin
        done_seen = 1;
        done_cyc  = n;
        chk("done_laser_off", int'(o_laser_en), 0);
        chk("done_busy", int'(o_busy), 1);
        tick();
        chk("done_one_cycle", int'(o_done), 0);
        chk("idle_busy", int'(o_busy), 0);
        chk("done_cycle", done_cyc, T[NW]);
        fin = 1'b1;
      end else if (v.abort_ch >= 0 && n == T[v.abort_ch] + 2) begin
        start   = 1'b0;
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_laser_en", int'(o_laser_en), 0);
        chk("abort_valid", int'(o_res_valid), 0);
        for (int j = 0; j < 20; j++) begin
          if (o_done) done_seen = 1;
          if (o_res_valid) chk("valid_after_abort", 1, 0);
          tick();
        end
        fin = 1'b1;
      end else begin
        if (o_res_valid && int'(o_res_ch) == v.stall_ch && stall_cnt < v.stall_len) begin
          ready = 1'b0;
          stall_cnt++;
          if (sbq.size() != 0) begin
            chk("stall_ch", int'(o_res_ch), sbq[0].ch);
            chk("stall_pd", int'(o_res_pd), int'(sbq[0].pd));
          end
        end else begin
          ready = 1'b1;
        end
        tick();
      end
    end
    start = 1'b0;
    ready = 1'b1;
    if (!fin) chk("sweep_timeout", 0, 1);
    chk("n_results", nhs - nhs0, v.exp_results);
    chk("done_seen", done_seen, v.exp_done);
    chk("queue_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //               center     spacing    pwr       mode base     stall   abort res done
    tbl[0] = '{16'd1000, 16'd50,   12'h800, 0, 12'd100,  -1, 0,  -1, 8, 1};
    tbl[1] = '{16'd200,  16'd3,    12'h123, 1, 12'd7,    -1, 0,  -1, 8, 1};
    tbl[2] = '{16'hFFF0, 16'h0008, 12'h0FF, 0, 12'h5A5,   2, 7,  -1, 8, 1};
    tbl[3] = '{16'd500,  16'd10,   12'h321, 0, 12'd42,   -1, 0,   4, 4, 0};
    tbl[4] = '{16'd1000, 16'd50,   12'h800, 0, 12'hFFF,  -1, 0,  -1, 8, 1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_laser_en", int'(o_laser_en), 0);
    chk("rst_wvl", int'(o_laser_wvl), 0);
    chk("rst_pwr", int'(o_laser_pwr), 0);
    chk("rst_valid", int'(o_res_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      run_sweep(tbl[t]);
      repeat (2) tick();
    end

    // asynchronous reset in the middle of ch1 ACCUM
    pd_mode = 0;
    pd_base = 12'hFFF;
    center  = 16'd300;
    spacing = 16'd20;
    pwr     = 12'h456;
    begin
      res_t e;
      e.ch = 0; e.pd = 12'hFFF; e.cyc = 1 + SET + ACC_N;
      sbq.push_back(e);
    end
    start = 1'b1;
    n = -1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && n < 16; i++) tick();
    chk("pre_reset_busy", int'(o_busy), 1);
    chk("pre_reset_laser_en", int'(o_laser_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_laser_en", int'(o_laser_en), 0);
    chk("async_rst_wvl", int'(o_laser_wvl), 0);
    chk("async_rst_pwr", int'(o_laser_pwr), 0);
    chk("async_rst_valid", int'(o_res_valid), 0);
    chk("async_rst_ch", int'(o_res_ch), 0);
    chk("async_rst_pd", int'(o_res_pd), 0);
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_done", int'(o_done), 0);
    chk("pre_reset_results", sbq.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_busy", int'(o_busy), 0);
    run_sweep(tbl[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
